// File: rtl/hdmi_fb_read_ctrl.sv
// rtl/hdmi_fb_read_ctrl.sv - frame-buffer burst request sequencer for hdmi_core
//
// Converts hdmi_core read strobes into burst requests (byte address + word
// count) on a req/ack/done memory-master handshake. Up to PEND_MAX chunk
// requests are queued so video timing never waits on bus latency.
//
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   enable             0: strobes ignored, returns to IDLE once nothing is in flight
//   fb_base/stride/hres frame geometry, captured on read_go
//   read_go/read_next_line/read_next_chunk/read_done  hdmi_core strobes
//   mst_req/mst_addr/mst_len  burst request, held until mst_ack
//   mst_ack/mst_done   master accept / burst completion
//   busy               FSM not in IDLE
//   overrun            sticky: a chunk strobe was dropped; cleared by read_go
module hdmi_fb_read_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int HRES_W      = 11,
  parameter int CHUNK_WORDS = 16,
  parameter int PEND_MAX    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [15:0]       stride,
  input  logic [HRES_W-1:0] hres,
  input  logic              read_go,
  input  logic              read_next_line,
  input  logic              read_next_chunk,
  input  logic              read_done,
  output logic              mst_req,
  output logic [ADDR_W-1:0] mst_addr,
  output logic [HRES_W-1:0] mst_len,
  input  logic              mst_ack,
  input  logic              mst_done,
  output logic              busy,
  output logic              overrun
);

  localparam int PEND_W = $clog2(PEND_MAX + 1);
  localparam logic [HRES_W-1:0] CHUNK_LEN = HRES_W'(CHUNK_WORDS);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] chunk_off;
  logic [HRES_W-1:0] words_left;
  logic [HRES_W-1:0] hres_q;
  logic [15:0]       stride_q;
  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pending_nxt;
  logic              frame_end;
  logic              overrun_q;
  logic [ADDR_W-1:0] mst_addr_q;
  logic [HRES_W-1:0] mst_len_q;

  logic              active;
  logic              go_s, line_s, done_s, chunk_s;
  logic              reload;
  logic [PEND_W-1:0] eff_pending;
  logic [HRES_W-1:0] eff_words;
  logic              chunk_ok, chunk_drop;
  logic              issue;
  logic [HRES_W-1:0] issue_len;
  logic              end_frame_now;

  // Strobe decode. read_go wins over everything else in the same cycle; a
  // chunk strobe coinciding with go/line counts against the new line.
  always_comb begin
    active      = (state != S_IDLE);
    go_s        = enable & read_go;
    line_s      = enable & read_next_line & active & ~go_s;
    done_s      = enable & read_done & active & ~go_s;
    chunk_s     = enable & read_next_chunk & (active | go_s) & ~done_s;
    reload      = go_s | line_s;
    eff_pending = reload ? '0 : pending;
    eff_words   = go_s ? hres : (line_s ? hres_q : words_left);
    chunk_ok    = chunk_s & (eff_pending != PEND_FULL) & (eff_words != '0);
    chunk_drop  = chunk_s & ~chunk_ok;
    issue_len   = (words_left > CHUNK_LEN) ? CHUNK_LEN : words_left;
    // A chunk arriving with nothing queued issues on the same edge (bypass),
    // giving mst_req one cycle after the strobe. Issue is held off while the
    // line/frame is being reloaded so it never mixes old and new geometry.
    issue       = (state == S_ARMED) & enable & ~reload & ~done_s &
                  (words_left != '0) & ((pending != '0) | chunk_ok);
    end_frame_now = (frame_end & ~go_s) | done_s | ~enable;
  end

  always_comb begin
    pending_nxt = eff_pending;
    if (done_s) begin
      pending_nxt = '0;
    end
    if (chunk_ok) begin
      pending_nxt = pending_nxt + PEND_W'(1);
    end
    if (issue) begin
      pending_nxt = pending_nxt - PEND_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go_s) begin
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        // Nothing is in flight here, so read_done (which also flushes the
        // queue) or losing enable can drop straight back to IDLE.
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (issue) begin
          state_nxt = S_ISSUE;
        end else if (done_s) begin
          state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mst_ack) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mst_done) begin
          state_nxt = end_frame_now ? S_IDLE : S_ARMED;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      line_addr  <= '0;
      chunk_off  <= '0;
      words_left <= '0;
      hres_q     <= '0;
      stride_q   <= '0;
      pending    <= '0;
      frame_end  <= 1'b0;
      overrun_q  <= 1'b0;
      mst_addr_q <= '0;
      mst_len_q  <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;

      if (go_s) begin
        line_addr  <= fb_base;
        stride_q   <= stride;
        hres_q     <= hres;
        chunk_off  <= '0;
        words_left <= hres;
        frame_end  <= 1'b0;
        overrun_q  <= 1'b0;
      end else if (line_s) begin
        line_addr  <= line_addr + ADDR_W'(stride_q);
        chunk_off  <= '0;
        words_left <= hres_q;
      end else if (issue) begin
        mst_addr_q <= line_addr + chunk_off;
        mst_len_q  <= issue_len;
        chunk_off  <= chunk_off + (ADDR_W'(issue_len) << 2);
        words_left <= words_left - issue_len;
      end

      if (done_s) begin
        frame_end <= 1'b1;
      end
      if (chunk_drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign mst_req  = (state == S_ISSUE);
  assign mst_addr = mst_addr_q;
  assign mst_len  = mst_len_q;
  assign busy     = (state != S_IDLE);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_hdmi_fb_read_ctrl.sv
// tb/tb_hdmi_fb_read_ctrl.sv - scoreboard bench for hdmi_fb_read_ctrl
module tb_hdmi_fb_read_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] fb_base;
  logic [15:0] stride;
  logic [10:0] hres;
  logic        read_go, read_next_line, read_next_chunk, read_done;
  logic        mst_req;
  logic [31:0] mst_addr;
  logic [10:0] mst_len;
  logic        mst_ack, mst_done;
  logic        busy, overrun;

  hdmi_fb_read_ctrl #(
    .ADDR_W(32), .HRES_W(11), .CHUNK_WORDS(16), .PEND_MAX(3)
  ) dut (
    .clock(clk), .reset(reset), .enable(enable),
    .fb_base(fb_base), .stride(stride), .hres(hres),
    .read_go(read_go), .read_next_line(read_next_line),
    .read_next_chunk(read_next_chunk), .read_done(read_done),
    .mst_req(mst_req), .mst_addr(mst_addr), .mst_len(mst_len),
    .mst_ack(mst_ack), .mst_done(mst_done),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [10:0] len;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_acc = 0;
  bit   auto_resp = 1'b0;
  bit   resp_active = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] a, input logic [10:0] l);
    exp_t e;
    e.addr = a;
    e.len  = l;
    q.push_back(e);
  endtask

  task automatic strobe(input bit g, input bit l, input bit c, input bit d);
    @(negedge clk);
    read_go = g; read_next_line = l; read_next_chunk = c; read_done = d;
    @(negedge clk);
    read_go = 0; read_next_line = 0; read_next_chunk = 0; read_done = 0;
  endtask

  task automatic wait_quiet(input int limit, input string tag);
    bit quiet;
    quiet = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #3;
      if (q.size() == 0 && !resp_active && !mst_req) begin
        quiet = 1'b1;
        break;
      end
    end
    check(tag, 64'(quiet), 64'd1);
  endtask

  // Auto responder: ack one cycle, complete the burst a few cycles later.
  initial begin
    mst_ack = 0;
    mst_done = 0;
    forever begin
      @(negedge clk);
      if (auto_resp && mst_req && !resp_active && !reset) begin
        resp_active = 1'b1;
        mst_ack = 1'b1;
        @(negedge clk);
        mst_ack = 1'b0;
        repeat (3) @(negedge clk);
        mst_done = 1'b1;
        @(negedge clk);
        mst_done = 1'b0;
        resp_active = 1'b0;
      end
    end
  end

  // Monitor: every accepted request is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && mst_req && mst_ack) begin
        n_acc++;
        check("req_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("req_addr", 64'(mst_addr), 64'(e.addr));
          check("req_len", 64'(mst_len), 64'(e.len));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    reset = 1; enable = 1;
    fb_base = 32'h1000; stride = 16'd5120; hres = 11'd1280;
    read_go = 0; read_next_line = 0; read_next_chunk = 0; read_done = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("rst_mst_req", 64'(mst_req), 0);
    check("rst_mst_addr", 64'(mst_addr), 0);
    check("rst_mst_len", 64'(mst_len), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_overrun", 64'(overrun), 0);

    // Single chunk: request one cycle after the strobe.
    auto_resp = 1;
    strobe(1, 0, 0, 0);
    check("go_busy", 64'(busy), 1);
    check("pre_req_low", 64'(mst_req), 0);
    push(32'h1000, 11'd16);
    strobe(0, 0, 1, 0);
    check("latency_req", 64'(mst_req), 1);
    wait_quiet(30, "quiet_t1");

    // hres=1000: 62 full bursts, one short, then a dropped chunk.
    hres = 11'd1000;
    strobe(1, 0, 0, 0);
    for (int i = 0; i < 63; i++) begin
      push(32'h1000 + 32'(i * 64), (i < 62) ? 11'd16 : 11'd8);
      strobe(0, 0, 1, 0);
      wait_quiet(30, "quiet_line");
    end
    check("no_overrun_63", 64'(overrun), 0);
    acc0 = n_acc;
    strobe(0, 0, 1, 0);
    check("overrun_64", 64'(overrun), 1);
    repeat (3) @(negedge clk);
    check("no_req_64", 64'(n_acc - acc0), 0);

    // Next line, then two chunks.
    strobe(0, 1, 0, 0);
    push(32'h1000 + 32'd5120, 11'd16);
    strobe(0, 0, 1, 0);
    wait_quiet(30, "quiet_nl1");
    push(32'h1000 + 32'd5184, 11'd16);
    strobe(0, 0, 1, 0);
    wait_quiet(30, "quiet_nl2");

    // Line and chunk together: exactly one request on the new line.
    acc0 = n_acc;
    push(32'h1000 + 32'd10240, 11'd16);
    strobe(0, 1, 1, 0);
    wait_quiet(30, "quiet_lc");
    repeat (5) @(negedge clk);
    check("line_chunk_one_req", 64'(n_acc - acc0), 1);

    // Queue saturation with ack held off.
    hres = 11'd1280;
    strobe(1, 0, 0, 0);
    check("go_clears_overrun", 64'(overrun), 0);
    auto_resp = 0;
    acc0 = n_acc;
    push(32'h1000, 11'd16);
    strobe(0, 0, 1, 0);
    check("sat_first_req", 64'(mst_req), 1);
    push(32'h1040, 11'd16);
    push(32'h1080, 11'd16);
    push(32'h10C0, 11'd16);
    for (int i = 0; i < 4; i++) strobe(0, 0, 1, 0);
    check("sat_overrun", 64'(overrun), 1);
    check("sat_req_held", 64'(mst_req), 1);
    auto_resp = 1;
    wait_quiet(100, "quiet_sat");
    repeat (5) @(negedge clk);
    // the in-flight burst plus the three queued ones
    check("sat_bursts", 64'(n_acc - acc0), 4);

    // read_go while a burst is in WAIT.
    auto_resp = 0;
    push(32'h1100, 11'd16);
    strobe(0, 0, 1, 0);
    @(negedge clk); mst_ack = 1;
    @(negedge clk); mst_ack = 0;
    check("wait_overrun_before", 64'(overrun), 1);
    fb_base = 32'h8000;
    strobe(1, 0, 0, 0);
    check("wait_go_overrun", 64'(overrun), 0);
    check("wait_go_busy", 64'(busy), 1);
    check("wait_go_no_req", 64'(mst_req), 0);
    @(negedge clk); mst_done = 1;
    @(negedge clk); mst_done = 0;
    check("after_done_busy", 64'(busy), 1);
    check("after_done_no_req", 64'(mst_req), 0);
    auto_resp = 1;
    push(32'h8000, 11'd16);
    strobe(0, 0, 1, 0);
    check("newframe_req", 64'(mst_req), 1);
    wait_quiet(30, "quiet_newframe");

    // Reset in ISSUE, then a stray mst_done.
    auto_resp = 0;
    acc0 = n_acc;
    strobe(0, 0, 1, 0);
    check("issue_req", 64'(mst_req), 1);
    check("issue_addr", 64'(mst_addr), 64'h8040);
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    check("midrst_req", 64'(mst_req), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_addr", 64'(mst_addr), 0);
    check("midrst_len", 64'(mst_len), 0);
    @(negedge clk); mst_done = 1;
    @(negedge clk); mst_done = 0;
    repeat (5) @(negedge clk);
    check("late_done_req", 64'(mst_req), 0);
    check("late_done_busy", 64'(busy), 0);
    check("late_done_acc", 64'(n_acc - acc0), 0);

    // enable=0: strobes ignored.
    enable = 0;
    strobe(1, 0, 0, 0);
    check("dis_busy", 64'(busy), 0);
    strobe(0, 0, 1, 0);
    check("dis_overrun", 64'(overrun), 0);
    check("dis_req", 64'(mst_req), 0);
    enable = 1;

    check("scoreboard_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
